ftoi_share_arb: RTL and testbench

- Shares one fixed-latency fp32→int32 conversion pipeline among NUM_REQ requesters.
- Performs round-robin issue into the converter and tags each operation with its requester index.
- Re-aligns tags with converter results through a delay line, then buffers the results in a tagged response FIFO with valid/ready backpressure.
- The converter itself has no stall input. This block therefore uses credit accounting so that no result can ever be dropped.

---
 rtl/ftoi_pkg.sv | 16 +
 rtl/ftoi_resp_fifo.sv | 79 +++++++
 rtl/ftoi_share_arb.sv | 160 ++++++++++++++++
 tb/tb_ftoi_share_arb.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftoi_pkg.sv
// Shared widths, default converter latency and the tagged response record
// used by the fp32->int32 share arbiter.
package ftoi_pkg;

  localparam int unsigned FP_W      = 32;
  localparam int unsigned INT_W     = 32;
  localparam int unsigned FTOI_LAT  = 7;
  // Widest tag needed for up to 16 requesters.
  localparam int unsigned MAX_TAG_W = 4;

  typedef struct packed {
    logic [MAX_TAG_W-1:0] tag;
    logic [INT_W-1:0]     data;
  } ftoi_resp_t;

endpackage

// File: rtl/ftoi_resp_fifo.sv
// Synchronous response FIFO: registered head entry plus a circular body,
// occupancy count output and same-cycle push/pop at any fill level.
module ftoi_resp_fifo
  import ftoi_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  ftoi_resp_t       push_data,
  input  logic             pop,
  output logic             head_valid,
  output ftoi_resp_t       head_data,
  output logic [CntW-1:0]  count,
  output logic             full
);

  localparam int unsigned BodyN = (Depth > 1) ? Depth - 1 : 1;
  localparam int unsigned PtrW  = (BodyN > 1) ? $clog2(BodyN) : 1;

  ftoi_resp_t      body_q [BodyN];
  ftoi_resp_t      head_q;
  logic            head_valid_q;
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] body_cnt_q;

  logic pop_eff, head_free, body_nonempty, body_rd, push_head, push_body;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BodyN - 1)) ? '0 : p + 1'b1;
  endfunction

  // The head refills from the body first; a push bypasses into the head only
  // when the body is empty, which keeps entries in push order.
  always_comb begin
    pop_eff       = pop && head_valid_q;
    head_free     = !head_valid_q || pop_eff;
    body_nonempty = (body_cnt_q != '0);
    body_rd       = head_free && body_nonempty;
    push_head     = push && head_free && !body_nonempty;
    push_body     = push && !push_head;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid_q <= 1'b0;
      head_q       <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      body_cnt_q   <= '0;
    end else begin
      if (body_rd) begin
        head_q   <= body_q[rd_ptr_q];
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end else if (push_head) begin
        head_q <= push_data;
      end
      head_valid_q <= !head_free || body_rd || push_head;
      if (push_body) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      body_cnt_q <= body_cnt_q + CntW'(push_body) - CntW'(body_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (push_body) begin
      body_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_valid = head_valid_q;
  assign head_data  = head_q;
  assign count      = CntW'(head_valid_q) + body_cnt_q;
  assign full       = (count == CntW'(Depth));

endmodule

// File: rtl/ftoi_share_arb.sv
// Round-robin share of one fixed-latency fp32->int32 converter with tagged,
// credit-protected response buffering. Optional perf counters: FTOI_ARB_PERF_EN.
module ftoi_share_arb
  import ftoi_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned LAT       = FTOI_LAT,
  parameter int unsigned OUT_DEPTH = 8,
  parameter int unsigned TAG_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*FP_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [FP_W-1:0]         conv_a,
  input  logic [INT_W-1:0]        conv_z,
  output logic                    resp_valid,
  output logic [INT_W-1:0]        resp_data,
  output logic [TAG_W-1:0]        resp_tag,
  input  logic                    resp_ready
`ifdef FTOI_ARB_PERF_EN
  ,
  output logic [31:0]             perf_issued,
  output logic [31:0]             perf_stall
`endif
);

  localparam int unsigned CntW = $clog2(OUT_DEPTH + 1);
  localparam int unsigned InfW = $clog2(LAT + 1);
  localparam int unsigned OccW = $clog2(LAT + OUT_DEPTH + 1);
  localparam int unsigned SW   = TAG_W + 1;

  logic [FP_W-1:0]  req_op [NUM_REQ];
  logic [TAG_W-1:0] rr_ptr_q;
  logic [InfW-1:0]  inflight_q;
  logic             dl_valid_q [LAT];
  logic [TAG_W-1:0] dl_tag_q [LAT];
  logic [CntW-1:0]  fifo_count;
  logic             fifo_full;
  logic             issue_ok, gnt_found, accept, retire;
  logic [TAG_W-1:0] gnt_idx, scan_idx;
  logic [SW-1:0]    scan_sum;
  ftoi_resp_t       push_data, head_data;
  logic             unused_tag;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_op
    assign req_op[i] = req_data[i*FP_W +: FP_W];
  end

  // A pop frees its credit only from the next cycle, so back-to-back issue
  // with a draining FIFO needs OUT_DEPTH >= LAT + 2.
  assign issue_ok = (OccW'(inflight_q) + OccW'(fifo_count)) < OccW'(OUT_DEPTH);

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + SW'(k);
      if (scan_sum >= SW'(NUM_REQ)) begin
        scan_sum = scan_sum - SW'(NUM_REQ);
      end
      scan_idx = scan_sum[TAG_W-1:0];
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  assign accept = !rst && issue_ok && gnt_found;
  assign retire = dl_valid_q[LAT-1];

  always_comb begin
    req_ready = '0;
    conv_a    = '0;
    if (accept) begin
      req_ready[gnt_idx] = 1'b1;
      conv_a             = req_op[gnt_idx];
    end
  end

  // Tag delay line mirrors the converter pipeline so tags meet their results.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      inflight_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        dl_valid_q[i] <= 1'b0;
        dl_tag_q[i]   <= '0;
      end
    end else begin
      dl_valid_q[0] <= accept;
      dl_tag_q[0]   <= gnt_idx;
      for (int i = 1; i < LAT; i++) begin
        dl_valid_q[i] <= dl_valid_q[i-1];
        dl_tag_q[i]   <= dl_tag_q[i-1];
      end
      if (accept) begin
        rr_ptr_q <= (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (accept && !retire) begin
        inflight_q <= inflight_q + 1'b1;
      end else if (!accept && retire) begin
        inflight_q <= inflight_q - 1'b1;
      end
    end
  end

  always_comb begin
    push_data      = '0;
    push_data.tag  = MAX_TAG_W'(dl_tag_q[LAT-1]);
    push_data.data = conv_z;
  end

  ftoi_resp_fifo #(
    .Depth (OUT_DEPTH),
    .CntW  (CntW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (retire),
    .push_data  (push_data),
    .pop        (resp_ready),
    .head_valid (resp_valid),
    .head_data  (head_data),
    .count      (fifo_count),
    .full       (fifo_full)
  );

  assign resp_data  = head_data.data;
  assign resp_tag   = head_data.tag[TAG_W-1:0];
  assign unused_tag = ^head_data.tag;

  assert property (@(posedge clk) disable iff (rst) !(retire && fifo_full));

`ifdef FTOI_ARB_PERF_EN
  logic [31:0] perf_issued_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (accept && (perf_issued_q != '1)) begin
        perf_issued_q <= perf_issued_q + 1'b1;
      end
      if ((|req_valid) && !issue_ok && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 1'b1;
      end
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_ftoi_share_arb.sv
// Directed bench for ftoi_share_arb with a behavioural LAT-cycle converter.
// Define FTOI_ARB_PERF_EN to also check the perf counters.
module tb_ftoi_share_arb;

  localparam int NUM_REQ = 4;
  localparam int LAT     = 7;

  logic                    clk;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*32-1:0]   req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic [31:0]             conv_a;
  logic [31:0]             conv_z;
  logic                    resp_valid;
  logic [31:0]             resp_data;
  logic [1:0]              resp_tag;
  logic                    resp_ready;
`ifdef FTOI_ARB_PERF_EN
  logic [31:0]             perf_issued;
  logic [31:0]             perf_stall;
`endif

  ftoi_share_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .conv_a     (conv_a),
    .conv_z     (conv_z),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .resp_ready (resp_ready)
`ifdef FTOI_ARB_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating fp32 -> int32 with saturation.
  function automatic logic [31:0] f2i(input logic [31:0] f);
    logic [31:0] m;
    logic [31:0] r;
    int          sh;
    m = {8'd0, 1'b1, f[22:0]};
    if (f[30:23] < 8'd127) begin
      r = 32'd0;
    end else begin
      sh = int'(f[30:23]) - 127;
      if (sh > 30) begin
        r = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        r = (sh >= 23) ? (m << (sh - 23)) : (m >> (23 - sh));
        if (f[31]) r = -r;
      end
    end
    return r;
  endfunction

  logic [31:0] conv_pipe [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) conv_pipe[i] <= 32'd0;
    end else begin
      conv_pipe[0] <= f2i(conv_a);
      for (int i = 1; i < LAT; i++) conv_pipe[i] <= conv_pipe[i-1];
    end
  end
  assign conv_z = conv_pipe[LAT-1];

  typedef struct {
    int          req;
    logic [31:0] fp;
    logic [31:0] z;
  } vec_t;

  typedef struct {
    logic [1:0]  tag;
    logic [31:0] data;
  } exp_t;

  vec_t vecs [7];
  exp_t exp_q [$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int i);
    return 4'b0001 << i;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_all_ops();
    req_data = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      cyc();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Single request from r; expects the response LAT+1 cycles after accept.
  task automatic issue_one(input int r, input logic [31:0] fp, input logic [31:0] z);
    int lat;
    resp_ready = 1'b1;
    req_data = '0;
    req_data[r*32 +: 32] = fp;
    req_valid = onehot(r);
    exp_q.push_back('{tag: 2'(r), data: z});
    @(negedge clk);
    check("single grant", 32'(req_ready), 32'(onehot(r)));
    check("single conv_a", conv_a, fp);
    cyc();
    req_valid = '0;
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 20) begin
      cyc();
      lat++;
      @(negedge clk);
    end
    check("single latency", 32'(lat), 32'd8);
    cyc();
  endtask

  // Response scoreboard plus hold-stability check under backpressure.
  initial begin
    exp_t        e;
    logic        hold_pend;
    logic [31:0] hold_data;
    logic [1:0]  hold_tag;
    hold_pend = 1'b0;
    hold_data = '0;
    hold_tag  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("hold valid", 32'(resp_valid), 32'd1);
          check("hold data", resp_data, hold_data);
          check("hold tag", 32'(resp_tag), 32'(hold_tag));
        end
        if (resp_valid && resp_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected response: got tag %0d data %h, want none",
                     resp_tag, resp_data);
          end else begin
            e = exp_q.pop_front();
            check("resp tag", 32'(resp_tag), 32'(e.tag));
            check("resp data", resp_data, e.data);
          end
        end
        hold_pend = resp_valid && !resp_ready;
        hold_data = resp_data;
        hold_tag  = resp_tag;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    vecs[0] = '{0, 32'h3F80_0000, 32'h0000_0001};
    vecs[1] = '{1, 32'hC000_0000, 32'hFFFF_FFFE};
    vecs[2] = '{2, 32'h4060_0000, 32'h0000_0003};
    vecs[3] = '{3, 32'hC060_0000, 32'hFFFF_FFFD};
    vecs[4] = '{1, 32'h3F00_0000, 32'h0000_0000};
    vecs[5] = '{2, 32'h4700_0000, 32'h0000_8000};
    vecs[6] = '{0, 32'h4B00_0001, 32'h0080_0001};

    // Reset state, with requests pending to show grants are suppressed.
    rst        = 1'b1;
    resp_ready = 1'b1;
    set_all_ops();
    req_valid  = '1;
    cyc();
    cyc();
    @(negedge clk);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_data", resp_data, 32'd0);
    check("rst resp_tag", 32'(resp_tag), 32'd0);
    check("rst conv_a", conv_a, 32'd0);
    do_reset();

    // Table-driven single conversions.
    for (int v = 0; v < 7; v++) begin
      repeat (2) cyc();
      issue_one(vecs[v].req, vecs[v].fp, vecs[v].z);
    end
    drain("table drain");
    check("inflight idle", 32'(dut.inflight_q), 32'd0);

    // Round-robin with continuous requests; credit stalls are tolerated only
    // once the first results start returning.
    do_reset();
    resp_ready = 1'b1;
    set_all_ops();
    req_valid = '1;
    g = 0;
    for (int c = 0; c < 24 && g < 12; c++) begin
      @(negedge clk);
      if (c < 8 || req_ready != '0) begin
        check("rr grant", 32'(req_ready), 32'(onehot(g % 4)));
        exp_q.push_back('{tag: 2'(g % 4), data: 32'(g % 4 + 1)});
        g++;
      end
      cyc();
    end
    req_valid = '0;
    check("rr grant count", 32'(g), 32'd12);
    drain("rr drain");

    // Backpressure: exactly OUT_DEPTH accepts, then hold until a pop.
    do_reset();
    set_all_ops();
    req_valid = '1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("bp grant", 32'(req_ready), (c < 8) ? 32'(onehot(c % 4)) : 32'd0);
      if (c < 8) exp_q.push_back('{tag: 2'(c % 4), data: 32'(c % 4 + 1)});
      cyc();
    end
    check("bp fifo full", 32'(dut.fifo_count), 32'd8);
`ifdef FTOI_ARB_PERF_EN
    check("bp perf_issued", perf_issued, 32'd8);
    check("bp perf_stall", perf_stall, 32'd8);
`endif
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp pop cycle no grant", 32'(req_ready), 32'd0);
    check("bp head tag", 32'(resp_tag), 32'd0);
    check("bp head data", resp_data, 32'd1);
    cyc();
    @(negedge clk);
    check("bp resume grant", 32'(req_ready), 32'(onehot(0)));
    exp_q.push_back('{tag: 2'd0, data: 32'd1});
    cyc();
    req_valid = '0;
    drain("bp drain");

    // Pop and retire-push in the same cycle with two entries buffered.
    do_reset();
    set_all_ops();
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("sim grant", 32'(req_ready), 32'(onehot(c)));
      exp_q.push_back('{tag: 2'(c), data: 32'(c + 1)});
      cyc();
    end
    req_valid = '0;
    repeat (6) cyc();
    resp_ready = 1'b1;
    @(negedge clk);
    check("sim count before", 32'(dut.fifo_count), 32'd2);
    cyc();
    @(negedge clk);
    check("sim count after", 32'(dut.fifo_count), 32'd2);
    check("sim head tag", 32'(resp_tag), 32'd1);
    check("sim head data", resp_data, 32'd2);
    cyc();
    drain("sim drain");

    // Reset with five operations in flight.
    do_reset();
    resp_ready = 1'b1;
    set_all_ops();
    req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("mid grant", 32'(req_ready), 32'(onehot(c % 4)));
      cyc();
    end
    req_valid = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
`ifdef FTOI_ARB_PERF_EN
    @(negedge clk);
    check("mid perf_issued", perf_issued, 32'd0);
    check("mid perf_stall", perf_stall, 32'd0);
`endif
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("mid quiet", 32'(resp_valid), 32'd0);
      cyc();
    end
    issue_one(2, 32'h4060_0000, 32'h0000_0003);
    drain("mid drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
